// File: rtl/point_parser.sv
// point_parser: parses ASCII "x,y,z\n" lines into coordinate triples on a valid/ready stream.
module point_parser #(
  parameter int NUM_POINTS = 1000,
  parameter int DIM_W = 17,
  localparam int CW = $clog2(NUM_POINTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_vld,
  output logic             byte_rdy,
  output logic [DIM_W-1:0] xloc,
  output logic [DIM_W-1:0] yloc,
  output logic [DIM_W-1:0] zloc,
  output logic             locs_vld,
  input  logic             locs_rdy,
  output logic [CW-1:0]    point_cnt,
  output logic             done,
  output logic             err
);
  typedef enum logic [2:0] {PX, PY, PZ, EMIT, DONE, ERR} state_t;
  state_t state, nxt;
  logic [DIM_W-1:0] acc, x, y, z;
  logic [DIM_W+3:0] sum;
  logic [CW-1:0] cnt;
  logic ne, parse, take, is_dig, is_com, is_nl, is_cr, ovf, last;
  always_comb begin
    parse = state == PX || state == PY || state == PZ;
    take = byte_vld && parse;
    is_dig = byte_in >= 8'h30 && byte_in <= 8'h39;
    is_com = byte_in == 8'h2C;
    is_nl = byte_in == 8'h0A;
    is_cr = byte_in == 8'h0D;
    // four guard bits catch any acc*10+d beyond the field width
    sum = {4'd0, acc} * (DIM_W+4)'(10) + {{DIM_W{1'b0}}, byte_in[3:0]};
    ovf = |sum[DIM_W+3:DIM_W];
    last = cnt == CW'(NUM_POINTS - 1);
  end
  always_ff @(posedge clk)
    if (rst) state <= PX;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (take)
      nxt = is_dig ? (ovf ? ERR : state) :
            is_cr  ? state :
            is_com ? (ne && state == PX ? PY : ne && state == PY ? PZ : ERR) :
            is_nl  ? (state == PX && !ne ? PX : state == PZ && ne ? EMIT : ERR) :
            ERR;
    else if (state == EMIT && locs_rdy)
      nxt = last ? DONE : PX;
  end
  always_comb begin
    byte_rdy = parse || state == ERR;
    locs_vld = state == EMIT;
    done = state == DONE;
    err = state == ERR;
    xloc = x;
    yloc = y;
    zloc = z;
    point_cnt = cnt;
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      ne <= 1'b0;
      x <= '0;
      y <= '0;
      z <= '0;
      cnt <= '0;
    end else begin
      if (take && is_dig && !ovf) begin
        acc <= sum[DIM_W-1:0];
        ne <= 1'b1;
      end
      if (take && (is_com || is_nl) && nxt != ERR) begin
        acc <= '0;
        ne <= 1'b0;
      end
      if (take && state == PX && nxt == PY) x <= acc;
      if (take && state == PY && nxt == PZ) y <= acc;
      if (take && state == PZ && nxt == EMIT) z <= acc;
      if (state == EMIT && locs_rdy) cnt <= cnt + 1'b1;
    end
endmodule

// File: doc/point_parser.md
Name: point_parser

Overview:
- Transmit side of the point-location stream consumed by the day-8 solver top.
- Parses an ASCII puzzle input, one byte per handshake, with lines of the form "x,y,z\n".
- Emits one (x,y,z) triple per line on a valid/ready interface that connects directly to the solver's xloc/yloc/zloc/locs_vld/locs_rdy inputs.
- Stops after NUM_POINTS points. Flags malformed input with a sticky error.

Parameters:
- NUM_POINTS, 1000: number of points to emit before done.
- DIM_W, 17: coordinate width in bits; must match the solver's DIM_W.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- byte_in  input  8  ASCII input byte.
- byte_vld  input  1  byte_in valid.
- byte_rdy  output  1  parser accepts byte_in this cycle.
- xloc  output  DIM_W  parsed x coordinate.
- yloc  output  DIM_W  parsed y coordinate.
- zloc  output  DIM_W  parsed z coordinate.
- locs_vld  output  1  triple valid.
- locs_rdy  input  1  downstream accepts the triple.
- point_cnt  output  $clog2(NUM_POINTS+1)  points handed off so far.
- done  output  1  NUM_POINTS points handed off; sticky.
- err  output  1  malformed input detected; sticky.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to PX; accumulator, field registers and point_cnt clear to 0.
  - Outputs after reset: locs_vld=0, done=0, err=0, xloc=yloc=zloc=0.
  - Reset mid-line or mid-EMIT discards the partial or pending point; no handshake completes in a reset cycle.
- Byte handshake:
  - A byte transfers when byte_vld && byte_rdy at a clk edge.
  - byte_rdy=1 in PX, PY, PZ and ERR; byte_rdy=0 in EMIT and DONE.
- States:
  - PX, PY, PZ: accumulate the current field.
  - EMIT: hold the triple for the downstream handshake.
  - DONE, ERR: terminal; exit only by reset.
- Per accepted byte in PX/PY/PZ:
  - Digit 0x30-0x39: acc <= acc*10 + (byte-0x30); the field is now non-empty.
  - 0x2C ',' in PX: x <= acc, clear acc, go to PY.
  - 0x2C ',' in PY: y <= acc, clear acc, go to PZ.
  - 0x0A '\n' in PZ: z <= acc, clear acc, go to EMIT.
  - 0x0A in PX with an empty field: blank line, ignored, stay in PX.
  - 0x0D '\r': ignored in any parse state.
- Errors. Each of the following sends the FSM to ERR:
  - any other byte;
  - ',' in PZ;
  - '\n' in PX or PY with a non-empty field;
  - a separator terminating an empty field;
  - a digit that makes acc*10+d exceed 2^DIM_W-1 (check done at DIM_W+4 bits; no wrap).
- ERR behaviour:
  - err=1, locs_vld=0.
  - byte_rdy stays 1 so bytes drain and are discarded; upstream never stalls.
- EMIT:
  - locs_vld=1; xloc/yloc/zloc driven from the field registers.
  - The triple stays stable while locs_vld && !locs_rdy.
  - On locs_vld && locs_rdy, point_cnt increments.
  - Next state is DONE if the new count equals NUM_POINTS, otherwise PX.
  - locs_vld deasserts the cycle after the handshake.
- Latency:
  - locs_vld rises in the cycle after the '\n' is accepted.
  - With locs_rdy=1, EMIT lasts 1 cycle, so there is one byte_rdy=0 bubble per point.
- DONE:
  - done=1, locs_vld=0, byte_rdy=0.
  - Trailing bytes are not consumed.
- locs_rdy is ignored outside EMIT.
- point_cnt never exceeds NUM_POINTS.

Test Plan:
- Basic line: NUM_POINTS=2. Send "162,817,812\n57,618,57\n" with locs_rdy=1.
  - Two triples: (162,817,812) then (57,618,57).
  - point_cnt=2, done=1, byte_rdy=0.
  - locs_vld rises exactly 1 cycle after each '\n' handshake.
- Backpressure: hold locs_rdy=0 for 5 cycles after locs_vld rises.
  - Triple held stable; byte_rdy=0 throughout.
  - Single transfer when locs_rdy rises; point_cnt increments once.
- CRLF and blank lines: "1,2,3\r\n\n4,5,6\r\n" with NUM_POINTS=2.
  - Triples (1,2,3) and (4,5,6); done=1; err=0.
- Overflow and bad input: DIM_W=17, field "131072".
  - err=1 on the final '2'; no locs_vld.
  - Subsequent bytes are accepted (byte_rdy=1) and discarded.
  - Separately, "1,,3\n" sets err on the second ','.
- Reset mid-operation:
  - Assert rst after "10,20," and after entering EMIT.
  - Outputs return to their reset values; point_cnt=0; no transfer in the reset cycle.
  - Next line "7,8,9\n" emits (7,8,9).
- Byte_vld gaps: random byte_vld deassertion throughout a 3-point input.
  - Triples are identical to the gap-free run.
